// File: rtl/fss_i2c_pkg.sv
// Shared I2C definitions for the FSS on-chip I2C peers.
//   i2c_state_e  : target FSM states
//   I2C_ACK/NACK : level of the ninth (acknowledge) bit
//   I2C_RW_WRITE : value of the R/W bit that selects a write transfer
//   drive_low()  : open-drain mapping from a bit value to the pull-low enable
package fss_i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        MACK,
        WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;
    localparam logic I2C_RW_WRITE = 1'b0;

    // Open drain: only a 0 is driven, a 1 is produced by releasing the line.
    function automatic logic drive_low(input logic bit_val);
        return (bit_val == 1'b0);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronises the asynchronous SCL/SDA pins and detects bus events.
// Ports:
//   clk, rst_n            : system clock, asynchronous active-low reset
//   scl, sda              : raw bus levels
//   scl_rise, scl_fall    : one-cycle pulses on synchronised SCL edges
//   start_det, stop_det   : one-cycle pulses for START / STOP conditions
//   sda_level             : synchronised SDA, aligned with the pulses above
// Every output appears P_SYNC_STAGES+1 clocks after the pin change.
module i2c_line_sync #(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_level
);

    logic [P_SYNC_STAGES-1:0] scl_sync_reg;
    logic [P_SYNC_STAGES-1:0] sda_sync_reg;
    logic [P_SYNC_STAGES:0]   scl_sync_next;
    logic [P_SYNC_STAGES:0]   sda_sync_next;
    logic scl_s;
    logic sda_s;
    logic scl_prev_reg;
    logic sda_prev_reg;
    logic scl_rise_reg;
    logic scl_fall_reg;
    logic start_reg;
    logic stop_reg;
    logic sda_level_reg;

    // One bit wider so the shift also works for a single-stage synchroniser.
    assign scl_sync_next = {scl_sync_reg, scl};
    assign sda_sync_next = {sda_sync_reg, sda};
    assign scl_s = scl_sync_reg[P_SYNC_STAGES-1];
    assign sda_s = sda_sync_reg[P_SYNC_STAGES-1];

    // Flops reset to the idle bus level (both high) so leaving reset on an
    // idle bus produces no spurious edge, START or STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_reg  <= '1;
            sda_sync_reg  <= '1;
            scl_prev_reg  <= 1'b1;
            sda_prev_reg  <= 1'b1;
            scl_rise_reg  <= 1'b0;
            scl_fall_reg  <= 1'b0;
            start_reg     <= 1'b0;
            stop_reg      <= 1'b0;
            sda_level_reg <= 1'b1;
        end else begin
            scl_sync_reg  <= scl_sync_next[P_SYNC_STAGES-1:0];
            sda_sync_reg  <= sda_sync_next[P_SYNC_STAGES-1:0];
            scl_prev_reg  <= scl_s;
            sda_prev_reg  <= sda_s;
            scl_rise_reg  <= scl_s & ~scl_prev_reg;
            scl_fall_reg  <= ~scl_s & scl_prev_reg;
            // SCL must be high both before and after the SDA transition.
            start_reg     <= scl_s & scl_prev_reg & ~sda_s & sda_prev_reg;
            stop_reg      <= scl_s & scl_prev_reg & sda_s & ~sda_prev_reg;
            sda_level_reg <= sda_s;
        end
    end

    assign scl_rise  = scl_rise_reg;
    assign scl_fall  = scl_fall_reg;
    assign start_det = start_reg;
    assign stop_det  = stop_reg;
    assign sda_level = sda_level_reg;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register bank with register-pointer
// addressing. First byte after the address sets the pointer, further write
// bytes land at the pointer (auto-increment); reads stream from the pointer.
// Ports:
//   I_CLK, I_NRESET   : system clock, asynchronous active-low reset
//   I_SCL, I_SDA      : asynchronous bus levels
//   O_SDA_PULL_LOW    : open-drain enable for SDA (1 = pull low)
//   O_BUSY            : addressed transaction in progress
//   O_WRITE_STROBE    : one-cycle pulse per register written
//   O_WRITE_ADDRESS   : register index of that write
//   O_WRITE_DATA      : byte written
module i2c_target_regs
    import fss_i2c_pkg::*;
#(
    parameter logic [6:0] P_TARGET_ADDRESS    = 7'h42,
    parameter int         P_NUM_REGS          = 16,
    parameter int         P_REG_ADDRESS_WIDTH = 4,
    parameter int         P_SYNC_STAGES       = 2
) (
    input  logic                           I_CLK,
    input  logic                           I_NRESET,
    input  logic                           I_SCL,
    input  logic                           I_SDA,
    output logic                           O_SDA_PULL_LOW,
    output logic                           O_BUSY,
    output logic                           O_WRITE_STROBE,
    output logic [P_REG_ADDRESS_WIDTH-1:0] O_WRITE_ADDRESS,
    output logic [7:0]                     O_WRITE_DATA
);

    localparam logic [P_REG_ADDRESS_WIDTH-1:0] PTR_ONE = 1;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_level;

    i2c_line_sync #(
        .P_SYNC_STAGES(P_SYNC_STAGES)
    ) u_line_sync (
        .clk       (I_CLK),
        .rst_n     (I_NRESET),
        .scl       (I_SCL),
        .sda       (I_SDA),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_level (sda_level)
    );

    i2c_state_e                     state_reg,   state_next;
    logic [3:0]                     bit_cnt_reg, bit_cnt_next;
    logic [7:0]                     shift_reg,   shift_next;
    logic [P_REG_ADDRESS_WIDTH-1:0] ptr_reg,     ptr_next;
    logic                           pull_reg,    pull_next;
    logic                           busy_reg,    busy_next;
    logic                           mack_ok_reg, mack_ok_next;
    logic                           strobe_reg,  strobe_next;
    logic [P_REG_ADDRESS_WIDTH-1:0] waddr_reg,   waddr_next;
    logic [7:0]                     wdata_reg,   wdata_next;
    logic [7:0]                     reg_bank_reg [P_NUM_REGS];

    logic [7:0] rx_byte;
    logic [7:0] rd_byte;

    // Byte as it will look once the bit sampled this cycle is shifted in.
    assign rx_byte = {shift_reg[6:0], sda_level};
    assign rd_byte = reg_bank_reg[ptr_reg];

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            ptr_reg     <= '0;
            pull_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            mack_ok_reg <= 1'b0;
            strobe_reg  <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            ptr_reg     <= ptr_next;
            pull_reg    <= pull_next;
            busy_reg    <= busy_next;
            mack_ok_reg <= mack_ok_next;
            strobe_reg  <= strobe_next;
            waddr_reg   <= waddr_next;
            wdata_reg   <= wdata_next;
        end
    end

    // Register bank is committed from the registered strobe, one cycle after
    // the last data bit; nothing can read it that soon.
    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            for (int i = 0; i < P_NUM_REGS; i++) begin
                reg_bank_reg[i] <= 8'h00;
            end
        end else if (strobe_reg) begin
            reg_bank_reg[waddr_reg] <= wdata_reg;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ptr_next     = ptr_reg;
        pull_next    = pull_reg;
        busy_next    = busy_reg;
        mack_ok_next = mack_ok_reg;
        strobe_next  = 1'b0;
        waddr_next   = waddr_reg;
        wdata_next   = wdata_reg;

        if (stop_det) begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            pull_next    = 1'b0;
            busy_next    = 1'b0;
            mack_ok_next = 1'b0;
        end else if (start_det) begin
            state_next   = ADDR;
            bit_cnt_next = '0;
            pull_next    = 1'b0;
            busy_next    = 1'b0;
            mack_ok_next = 1'b0;
        end else begin
            unique case (state_reg)
                IDLE, WAIT_STOP: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = '0;
                            if (rx_byte[7:1] == P_TARGET_ADDRESS) begin
                                state_next = ADDR_ACK;
                                busy_next  = 1'b1;
                            end else begin
                                state_next = IDLE;
                            end
                        end
                    end
                end

                // ACK states: SDA is always released on entry, so pull_reg
                // doubles as the phase flag. First falling edge drives the
                // ACK, second one ends it.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!pull_reg) begin
                            pull_next = drive_low(I2C_ACK);
                        end else if (shift_reg[0] == I2C_RW_WRITE) begin
                            pull_next  = 1'b0;
                            state_next = PTR;
                        end else begin
                            // First read bit goes out on this same edge.
                            shift_next   = rd_byte;
                            pull_next    = drive_low(rd_byte[7]);
                            bit_cnt_next = '0;
                            state_next   = READ;
                        end
                    end
                end

                PTR: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = '0;
                            ptr_next     = rx_byte[P_REG_ADDRESS_WIDTH-1:0];
                            state_next   = PTR_ACK;
                        end
                    end
                end

                PTR_ACK: begin
                    if (scl_fall) begin
                        if (!pull_reg) begin
                            pull_next = drive_low(I2C_ACK);
                        end else begin
                            pull_next  = 1'b0;
                            state_next = WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = '0;
                            strobe_next  = 1'b1;
                            waddr_next   = ptr_reg;
                            wdata_next   = rx_byte;
                            state_next   = WRITE_ACK;
                        end
                    end
                end

                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!pull_reg) begin
                            pull_next = drive_low(I2C_ACK);
                        end else begin
                            pull_next  = 1'b0;
                            ptr_next   = ptr_reg + PTR_ONE;
                            state_next = WRITE;
                        end
                    end
                end

                // bit_cnt counts bits the initiator has sampled; the next
                // bit is shifted out on each falling edge until all 8 went.
                READ: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            bit_cnt_next = '0;
                            pull_next    = 1'b0;
                            state_next   = MACK;
                        end else begin
                            shift_next = {shift_reg[6:0], 1'b0};
                            pull_next  = drive_low(shift_reg[6]);
                        end
                    end
                end

                // The ACK is sampled on the rising edge, but the next byte
                // can only start on the following falling edge.
                MACK: begin
                    if (scl_rise) begin
                        if (sda_level == I2C_NACK) begin
                            busy_next  = 1'b0;
                            state_next = WAIT_STOP;
                        end else begin
                            ptr_next     = ptr_reg + PTR_ONE;
                            mack_ok_next = 1'b1;
                        end
                    end else if (scl_fall && mack_ok_reg) begin
                        mack_ok_next = 1'b0;
                        shift_next   = rd_byte;
                        pull_next    = drive_low(rd_byte[7]);
                        bit_cnt_next = '0;
                        state_next   = READ;
                    end
                end

                default: begin
                    state_next = IDLE;
                    pull_next  = 1'b0;
                    busy_next  = 1'b0;
                end
            endcase
        end
    end

    assign O_SDA_PULL_LOW  = pull_reg;
    assign O_BUSY          = busy_reg;
    assign O_WRITE_STROBE  = strobe_reg;
    assign O_WRITE_ADDRESS = waddr_reg;
    assign O_WRITE_DATA    = wdata_reg;

endmodule

// File: tb/tb_i2c_target_regs.sv
module tb_i2c_target_regs;
    import fss_i2c_pkg::*;

    localparam int         Q      = 10;     // quarter bit period in clocks
    localparam logic [7:0] ADDR_W = 8'h84;
    localparam logic [7:0] ADDR_R = 8'h85;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic pull;
    logic busy;
    logic strobe;
    logic [3:0] waddr;
    logic [7:0] wdata;
    wire  sda_bus;

    // Open-drain bus: low if either side pulls.
    assign sda_bus = m_sda & ~pull;

    always #10 clk = ~clk;

    i2c_target_regs #(
        .P_TARGET_ADDRESS    (7'h42),
        .P_NUM_REGS          (16),
        .P_REG_ADDRESS_WIDTH (4),
        .P_SYNC_STAGES       (2)
    ) dut (
        .I_CLK           (clk),
        .I_NRESET        (rst_n),
        .I_SCL           (m_scl),
        .I_SDA           (sda_bus),
        .O_SDA_PULL_LOW  (pull),
        .O_BUSY          (busy),
        .O_WRITE_STROBE  (strobe),
        .O_WRITE_ADDRESS (waddr),
        .O_WRITE_DATA    (wdata)
    );

    int checks     = 0;
    int failures   = 0;
    int strobe_cnt = 0;

    // Reference model: register contents, pointer, pending expected writes.
    logic [7:0]  model_regs [16];
    int          model_ptr;
    logic [11:0] exp_q [$];

    // Write scoreboard: each strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && strobe) begin
            strobe_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_strobe got addr=%0d data=%02h exp=none", waddr, wdata);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({waddr, wdata} !== e) begin
                    failures++;
                    $display("FAIL strobe got addr=%0d data=%02h exp addr=%0d data=%02h",
                             waddr, wdata, e[11:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #1_600_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bus functional model ----------------
    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; clk_wait(Q);
        m_scl = 1'b1; clk_wait(Q);
        m_sda = 1'b0; clk_wait(Q);
        m_scl = 1'b0; clk_wait(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; clk_wait(Q);
        m_scl = 1'b1; clk_wait(Q);
        m_sda = 1'b1; clk_wait(Q);
    endtask

    task automatic bus_bit(input logic b, output logic rd);
        m_sda = b;    clk_wait(Q);
        m_scl = 1'b1; clk_wait(Q);
        rd = sda_bus; clk_wait(Q);
        m_scl = 1'b0; clk_wait(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic rd;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], rd);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic mack);
        logic rd;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, rd);
            b[i] = rd;
        end
        bus_bit(mack, rd);
    endtask

    // Write transaction: pointer byte then n data bytes, then STOP.
    task automatic txn_write(input logic [7:0] ptr_byte, input int n);
        logic ack;
        logic [7:0] d;
        bus_start();
        write_byte(ADDR_W, ack);
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL wr_addr_ack got=%b exp=0", ack); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL wr_busy got=%b exp=1", busy); end
        write_byte(ptr_byte, ack);
        model_ptr = int'(ptr_byte) % 16;
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL ptr_ack got=%b exp=0", ack); end
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            exp_q.push_back({4'(model_ptr), d});
            model_regs[model_ptr] = d;
            model_ptr = (model_ptr + 1) % 16;
            write_byte(d, ack);
            checks++;
            if (ack !== I2C_ACK) begin failures++; $display("FAIL data_ack byte=%0d got=%b exp=0", i, ack); end
        end
        bus_stop();
        clk_wait(4);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_stop got=%b exp=0", busy); end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL strobes_missing got=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
        $display("write ptr=%02h bytes=%0d", ptr_byte, n);
    endtask

    // Read transaction of n bytes from the current pointer, last one NACKed.
    task automatic txn_read(input int n);
        logic ack;
        logic [7:0] d;
        logic [7:0] e;
        bus_start();
        write_byte(ADDR_R, ack);
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL rd_addr_ack got=%b exp=0", ack); end
        for (int i = 0; i < n; i++) begin
            e = model_regs[model_ptr];
            read_byte(d, (i == n - 1) ? I2C_NACK : I2C_ACK);
            checks++;
            if (d !== e) begin failures++; $display("FAIL rd_data byte=%0d got=%02h exp=%02h", i, d, e); end
            if (i != n - 1) model_ptr = (model_ptr + 1) % 16;
            $display("read byte=%0d data=%02h", i, d);
        end
        checks++;
        if ({pull, busy} !== 2'b00) begin
            failures++;
            $display("FAIL after_nack got pull=%b busy=%b exp=0/0", pull, busy);
        end
        bus_stop();
        clk_wait(4);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic rd;
        logic ack;
        logic [7:0] d;
        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        clk_wait(5);
        checks++;
        if ({pull, busy, strobe, waddr, wdata} !== 15'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {pull, busy, strobe, waddr, wdata});
        end
        rst_n = 1'b1;
        clk_wait(5);
        checks++;
        if ({pull, busy, strobe, waddr, wdata} !== 15'd0) begin
            failures++;
            $display("FAIL post_reset_outputs got=%h exp=0", {pull, busy, strobe, waddr, wdata});
        end
        // Reset while the target is driving the address ACK.
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(ADDR_W[i], rd);
        m_sda = 1'b1; clk_wait(Q);
        m_scl = 1'b1; clk_wait(Q);
        checks++;
        if (sda_bus !== 1'b0) begin failures++; $display("FAIL ack_before_reset got=%b exp=0", sda_bus); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pull, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release_sda got pull=%b busy=%b exp=0/0", pull, busy);
        end
        m_scl = 1'b0; clk_wait(Q);
        m_scl = 1'b1; clk_wait(Q);
        rst_n = 1'b1;
        clk_wait(5);
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        exp_q.delete();
        bus_start();
        write_byte(ADDR_R, ack);
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL reset_rd_ack got=%b exp=0", ack); end
        read_byte(d, I2C_NACK);
        checks++;
        if (d !== 8'h00) begin failures++; $display("FAIL reset_reg0 got=%02h exp=00", d); end
        bus_stop();
        clk_wait(4);
        $display("reset reg0=%02h", d);
    endtask

    task automatic test_write_basic();
        logic ack;
        bus_start();
        write_byte(ADDR_W, ack);
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL basic_addr_ack got=%b exp=0", ack); end
        write_byte(8'h03, ack);
        model_ptr = 3;
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL basic_ptr_ack got=%b exp=0", ack); end
        exp_q.push_back({4'd3, 8'hA5});
        exp_q.push_back({4'd4, 8'h5A});
        model_regs[3] = 8'hA5;
        model_regs[4] = 8'h5A;
        model_ptr = 5;
        write_byte(8'hA5, ack);
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL basic_d0_ack got=%b exp=0", ack); end
        write_byte(8'h5A, ack);
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL basic_d1_ack got=%b exp=0", ack); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        bus_stop();
        clk_wait(4);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_stop got=%b exp=0", busy); end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_strobes got=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
        $display("write_basic done");
    endtask

    task automatic test_read_wrap();
        logic ack;
        logic [7:0] d;
        logic [7:0] e;
        txn_write(8'h0F, 3);
        bus_start();
        write_byte(ADDR_W, ack);
        write_byte(8'h0F, ack);
        model_ptr = 15;
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL wrap_ptr_ack got=%b exp=0", ack); end
        bus_start();
        write_byte(ADDR_R, ack);
        checks++;
        if (ack !== I2C_ACK) begin failures++; $display("FAIL wrap_rd_ack got=%b exp=0", ack); end
        for (int i = 0; i < 3; i++) begin
            e = model_regs[model_ptr];
            read_byte(d, (i == 2) ? I2C_NACK : I2C_ACK);
            checks++;
            if (d !== e) begin failures++; $display("FAIL wrap_data byte=%0d got=%02h exp=%02h", i, d, e); end
            if (i != 2) model_ptr = (model_ptr + 1) % 16;
            $display("wrap read byte=%0d data=%02h", i, d);
        end
        checks++;
        if ({pull, busy} !== 2'b00) begin
            failures++;
            $display("FAIL wrap_after_nack got pull=%b busy=%b exp=0/0", pull, busy);
        end
        bus_stop();
        clk_wait(4);
    endtask

    task automatic test_wrong_addr();
        logic ack;
        int s0;
        s0 = strobe_cnt;
        bus_start();
        write_byte(8'h90, ack);
        checks++;
        if (ack !== I2C_NACK) begin failures++; $display("FAIL wrong_addr_ack got=%b exp=1", ack); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL wrong_addr_busy got=%b exp=0", busy); end
        write_byte(8'h01, ack);
        write_byte(8'($urandom), ack);
        checks++;
        if (ack !== I2C_NACK) begin failures++; $display("FAIL wrong_addr_data_ack got=%b exp=1", ack); end
        bus_stop();
        clk_wait(4);
        checks++;
        if (strobe_cnt != s0) begin failures++; $display("FAIL wrong_addr_strobe got=%0d exp=%0d", strobe_cnt, s0); end
        $display("wrong_addr ack=%b", ack);
    endtask

    task automatic test_stop_mid();
        logic ack;
        logic rd;
        int s0;
        int p;
        p = int'($urandom_range(0, 15));
        bus_start();
        write_byte(ADDR_W, ack);
        write_byte(8'(p), ack);
        model_ptr = p;
        s0 = strobe_cnt;
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), rd);
        bus_stop();
        clk_wait(4);
        checks++;
        if (strobe_cnt != s0) begin failures++; $display("FAIL stop_mid_strobe got=%0d exp=%0d", strobe_cnt, s0); end
        checks++;
        if ({pull, busy} !== 2'b00) begin
            failures++;
            $display("FAIL stop_mid_idle got pull=%b busy=%b exp=0/0", pull, busy);
        end
        $display("stop_mid ptr=%0d", p);
        txn_read(1);
    endtask

    task automatic test_ptr_upper();
        txn_write(8'hF7, 1);
        txn_write(8'hF7, 0);
        txn_read(1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 10; t++) begin
            if ($urandom_range(0, 1) == 0) txn_write(8'($urandom), int'($urandom_range(0, 3)));
            else txn_read(int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wrap();
        test_wrong_addr();
        test_stop_mid();
        test_ptr_upper();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
